bus_demux_4: RTL and testbench
==============================

Name: bus_demux_4

Overview:
- Routes one initiator-side memory request stream (the core's data-memory port) to one of four target ports, selected by two address bits.
- Returns the selected target's response to the initiator.
- Allows a single outstanding transaction.
- A per-transaction timeout returns an error response if a target never answers.
- Sits between the core's load/store unit and the RAM/ROM/peripheral targets.

Parameters:
- D_WIDTH, 32, data width.
- A_WIDTH, 32, address width.
- SEL_LSB, 28, target index = addr[SEL_LSB+1:SEL_LSB].
- TIMEOUT, 255, cycles in ISSUE+WAIT before error response (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req_valid  in  1  initiator request valid.
- m_req_ready  out  1  request accepted when valid&ready.
- m_addr  in  A_WIDTH  request address.
- m_wdata  in  D_WIDTH  write data.
- m_we  in  1  1=write, 0=read.
- m_resp_valid  out  1  one-cycle response pulse.
- m_rdata  out  D_WIDTH  read data; 0 on writes and on error.
- m_err  out  1  valid with m_resp_valid; 1 = timeout.
- s_req_valid  out  4  one-hot request valid to target i.
- s_req_ready  in  4  target i accepts.
- s_addr  out  A_WIDTH  latched address, shared by all targets.
- s_wdata  out  D_WIDTH  latched write data, shared.
- s_we  out  1  latched write enable, shared.
- s_resp_valid  in  4  target i response (read data or write ack).
- s_rdata  in  4*D_WIDTH  target i data at [i*D_WIDTH +: D_WIDTH].

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except m_req_ready=1; latches and timer cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - m_req_ready=1.
  - On m_req_valid: latch addr/wdata/we and sel=m_addr[SEL_LSB+1:SEL_LSB]; clear timer; go to ISSUE.
- ISSUE:
  - s_req_valid[sel]=1; other bits 0; m_req_ready=0.
  - On s_req_ready[sel]: go to WAIT.
  - s_req_ready on non-selected bits is ignored.
- WAIT:
  - s_req_valid=0.
  - On s_resp_valid[sel]: capture s_rdata slice sel (0 if write) into m_rdata; err=0; go to RESP.
  - Responses from non-selected targets are ignored.
- Timer:
  - Increments every cycle in ISSUE and WAIT.
  - When timer==TIMEOUT and no handshake/response occurs that cycle: m_rdata=0, err=1, go to RESP.
  - If s_req_valid is dropped on a timeout from ISSUE, the target must not complete the request later.
  - A response arriving in the same cycle as the timeout wins: err=0.
- RESP: m_resp_valid=1 for exactly one cycle with m_rdata/m_err stable; then IDLE.
- m_rdata/m_err hold their value after RESP until the next RESP; m_resp_valid=0 outside RESP.
- s_addr/s_wdata/s_we are stable from ISSUE entry until the next accept.
- Latency: accept at cycle N; with a zero-wait target, ISSUE handshake at N+1, response at N+2, m_resp_valid at N+3. Minimum turnaround is 4 cycles per transaction.
- Back-to-back: a new request can be accepted the cycle after RESP.
- m_req_valid while not in IDLE is not consumed.
- Reset mid-transaction: immediate return to IDLE; s_req_valid drops asynchronously; no response is issued for the aborted transaction.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP).
  - NUM_TARGETS=4.
  - SEL_W=2.
  - Target index constants (RAM=0, ROM=1, PERIPH=2, SPARE=3).
- Sub-module timeout_counter:
  - Inputs: clear, enable.
  - Output: expired at count==TIMEOUT.
  - Asynchronous active-low reset.

Test Plan:
- Read, target 2, zero-wait: m_addr=0x2000_0004, target returns 0xDEAD_BEEF → s_req_valid=4'b0100 for 1 cycle; m_resp_valid at N+3 with m_rdata=0xDEAD_BEEF, m_err=0.
- Write, target 1, ready delayed 3 cycles: m_addr=0x1000_0010, m_wdata=0x1234_5678, m_we=1 → s_req_valid=4'b0010 held 4 cycles with s_wdata=0x1234_5678; after ack, m_resp_valid with m_rdata=0, m_err=0.
- Distractor responses: select target 0; targets 1 and 3 assert s_resp_valid during WAIT → ignored; only target 0's data (0x0000_00AA) is returned.
- Timeout with TIMEOUT=8: target 3 never responds → m_resp_valid with m_err=1, m_rdata=0 exactly 8 cycles after ISSUE entry; returns to IDLE; next request succeeds.
- Async reset asserted in WAIT: s_req_valid=0 and m_req_ready=1 without waiting for a clock edge; no m_resp_valid; a fresh read after release completes normally.
- Back-to-back reads to targets 0 then 3 with m_req_valid held high → second accept occurs the cycle after the first RESP; responses are returned in order with correct data.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state type, target indices and select helper for the request demux.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int NUM_TARGETS = 4;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] TGT_RAM = 2'd0;
  localparam logic [SEL_W-1:0] TGT_ROM = 2'd1;
  localparam logic [SEL_W-1:0] TGT_PERIPH = 2'd2;
  localparam logic [SEL_W-1:0] TGT_SPARE = 2'd3;
  function automatic logic [NUM_TARGETS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_TARGETS'(1) << sel;
  endfunction
endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: counts cycles spent on one transaction and flags when the budget is used up.
module timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  assign expired = cnt_q == W'(TIMEOUT);
  // Clear preloads 1 so the count already includes the first cycle of the transaction.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clear) cnt_q <= W'(1);
    else if (enable && !expired) cnt_q <= cnt_q + W'(1);
endmodule

// File: rtl/bus_demux_4.sv
// bus_demux_4: routes one request stream to four targets with a single outstanding transaction
// and an error response when the selected target stays silent too long.
module bus_demux_4
  import bus_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m_req_valid,
  output logic                           m_req_ready,
  input  logic [A_WIDTH-1:0]             m_addr,
  input  logic [D_WIDTH-1:0]             m_wdata,
  input  logic                           m_we,
  output logic                           m_resp_valid,
  output logic [D_WIDTH-1:0]             m_rdata,
  output logic                           m_err,
  output logic [NUM_TARGETS-1:0]         s_req_valid,
  input  logic [NUM_TARGETS-1:0]         s_req_ready,
  output logic [A_WIDTH-1:0]             s_addr,
  output logic [D_WIDTH-1:0]             s_wdata,
  output logic                           s_we,
  input  logic [NUM_TARGETS-1:0]         s_resp_valid,
  input  logic [NUM_TARGETS*D_WIDTH-1:0] s_rdata
);
  state_e                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic [A_WIDTH-1:0]     addr_q;
  logic [D_WIDTH-1:0]     wdata_q;
  logic [D_WIDTH-1:0]     rdata_q;
  logic                   we_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic                   err_q;
  logic [NUM_TARGETS-1:0] req_valid_q;
  logic [SEL_W-1:0]       sel_in;
  logic [D_WIDTH-1:0]     rdata_sel;
  logic                   accept;
  logic                   hs;
  logic                   rsp;
  logic                   expired;
  assign sel_in = m_addr[SEL_LSB +: SEL_W];
  assign rdata_sel = s_rdata[int'(sel_q) * D_WIDTH +: D_WIDTH];
  assign accept = state_q == IDLE && m_req_valid;
  assign hs = s_req_ready[sel_q];
  assign rsp = s_resp_valid[sel_q];
  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept),
    .enable(state_q == ISSUE || state_q == WAIT),
    .expired(expired)
  );
  // A handshake or response in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      req_valid_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (m_req_valid) begin
          sel_q <= sel_in;
          addr_q <= m_addr;
          wdata_q <= m_wdata;
          we_q <= m_we;
          req_valid_q <= sel_onehot(sel_in);
          req_ready_q <= 1'b0;
          state_q <= ISSUE;
        end
        ISSUE: if (hs) begin
          req_valid_q <= '0;
          state_q <= WAIT;
        end else if (expired) begin
          req_valid_q <= '0;
          rdata_q <= '0;
          err_q <= 1'b1;
          resp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        WAIT: if (rsp || expired) begin
          rdata_q <= (rsp && !we_q) ? rdata_sel : '0;
          err_q <= !rsp;
          resp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign m_req_ready = req_ready_q;
  assign m_resp_valid = resp_valid_q;
  assign m_rdata = rdata_q;
  assign m_err = err_q;
  assign s_req_valid = req_valid_q;
  assign s_addr = addr_q;
  assign s_wdata = wdata_q;
  assign s_we = we_q;
endmodule

// File: tb/tb_bus_demux_4.sv
// tb_bus_demux_4: randomized targets checked every cycle against a transaction-schedule model.
module tb_bus_demux_4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic m_req_valid, m_req_ready, m_we, m_resp_valid, m_err, s_we;
  logic [AW-1:0] m_addr, s_addr;
  logic [DW-1:0] m_wdata, m_rdata, s_wdata;
  logic [3:0] s_req_valid, s_req_ready, s_resp_valid;
  logic [4*DW-1:0] s_rdata;
  always #5 clk = ~clk;
  bus_demux_4 #(.D_WIDTH(DW), .A_WIDTH(AW), .SEL_LSB(28), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_we(m_we), .m_resp_valid(m_resp_valid),
    .m_rdata(m_rdata), .m_err(m_err), .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );
  int cyc, checks, errors, srv_cnt;
  bit acc_flag, noise, distract;
  // Model: one scheduled transaction described by the cycles at which things must happen.
  bit t_active, t_ok, t_res_err;
  int t_n, t_e, t_hs, t_rsp, t_end, t_resp;
  logic [1:0] t_sel;
  logic [31:0] t_data, t_res_rdata;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  bit exp_err, exp_we;
  int p_r, p_w;
  logic [31:0] p_data;
  typedef struct {int c; logic [31:0] d; logic e;} obs_t;
  obs_t obs_q[$];
  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction
  function automatic bit idle(input int c);
    return !t_active || c > t_resp;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic compare();
    logic [3:0] srv;
    srv = (t_active && cyc >= t_e && cyc <= t_end) ? oh(t_sel) : 4'b0000;
    chk("m_req_ready", m_req_ready, idle(cyc));
    chk("s_req_valid", s_req_valid, srv);
    chk("m_resp_valid", m_resp_valid, t_active && cyc == t_resp);
    chk("m_rdata", m_rdata, exp_rdata);
    chk("m_err", m_err, exp_err);
    chk("s_addr", s_addr, exp_addr);
    chk("s_wdata", s_wdata, exp_wdata);
    chk("s_we", s_we, exp_we);
    if (m_resp_valid === 1'b1) obs_q.push_back('{cyc, m_rdata, m_err});
    if (s_req_valid !== 4'b0000) srv_cnt++;
  endtask
  task automatic model_reset();
    t_active = 0;
    exp_rdata = '0; exp_err = 0; exp_addr = '0; exp_wdata = '0; exp_we = 0;
  endtask
  task automatic schedule();
    int tl, dl;
    t_active = 1;
    t_n = cyc;
    t_e = cyc + 1;
    t_sel = m_addr[29:28];
    t_hs = t_e + p_r;
    t_rsp = t_hs + 1 + p_w;
    t_data = p_data;
    tl = t_e + TO - 1;
    if (t_hs > tl) begin
      t_end = tl; t_ok = 0; t_resp = tl + 1;
    end else begin
      t_end = t_hs;
      dl = (t_hs + 1 > tl) ? t_hs + 1 : tl;
      t_ok = t_rsp <= dl;
      t_resp = t_ok ? t_rsp + 1 : dl + 1;
    end
    t_res_rdata = (t_ok && !m_we) ? p_data : 32'h0;
    t_res_err = !t_ok;
    exp_addr = m_addr; exp_wdata = m_wdata; exp_we = m_we;
  endtask
  task automatic drive_targets();
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = $urandom;
    s_req_ready = noise ? 4'($urandom) : 4'b0000;
    s_resp_valid = noise ? 4'($urandom) : 4'b0000;
    if (t_active) begin
      mask = ~oh(t_sel);
      s_req_ready &= mask;
      s_resp_valid &= mask;
      if (distract) s_resp_valid |= mask;
      if (cyc == t_hs && t_hs <= t_end) s_req_ready[t_sel] = 1'b1;
      if (t_ok && cyc == t_rsp) begin
        s_resp_valid[t_sel] = 1'b1;
        s_rdata[int'(t_sel)*32 +: 32] = t_data;
      end
    end
  endtask
  task automatic end_cycle();
    @(negedge clk);
    compare();
    acc_flag = 0;
    if (rst_n && m_req_valid && idle(cyc)) begin
      schedule();
      acc_flag = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (t_active && cyc == t_resp) begin
      exp_rdata = t_res_rdata;
      exp_err = t_res_err;
    end
    drive_targets();
  endtask
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input bit we,
                     input int r, input int w, input logic [31:0] d);
    int k;
    m_req_valid = 1; m_addr = a; m_wdata = wd; m_we = we;
    p_r = r; p_w = w; p_data = d;
    k = 0;
    do begin end_cycle(); k++; end while (!acc_flag && k < 100);
    if (!acc_flag) begin errors++; $display("FAIL accept_bound cyc=%0d", cyc); end
    m_req_valid = 0; m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom);
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (!idle(cyc) && k < 100) begin end_cycle(); k++; end
  endtask
  task automatic pop_obs(output obs_t o);
    o = '{-1, 32'hx, 1'bx};
    if (obs_q.size() > 0) o = obs_q.pop_front();
  endtask
  obs_t o, o2;
  int n0;
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    rst_n = 0; m_req_valid = 0; m_addr = '0; m_wdata = '0; m_we = 0;
    noise = 0; distract = 0; cyc = 0; checks = 0; errors = 0;
    model_reset();
    drive_targets();
    repeat (3) end_cycle();
    chk("reset_ready", m_req_ready, 1'b1);
    chk("reset_sreq", s_req_valid, 4'b0000);
    #1 rst_n = 1;
    repeat (2) end_cycle();
    // Read from target 2, zero wait.
    obs_q.delete(); srv_cnt = 0;
    txn(32'h2000_0004, 32'h0, 0, 0, 0, 32'hDEAD_BEEF); n0 = t_n; wait_idle();
    pop_obs(o);
    chk("rd_latency", o.c - n0, 3);
    chk("rd_data", o.d, 32'hDEAD_BEEF);
    chk("rd_err", o.e, 1'b0);
    chk("rd_sreq_cycles", srv_cnt, 1);
    // Write to target 1, ready after 3 cycles.
    srv_cnt = 0;
    txn(32'h1000_0010, 32'h1234_5678, 1, 3, 0, 32'hFFFF_FFFF); wait_idle();
    pop_obs(o);
    chk("wr_sreq_cycles", srv_cnt, 4);
    chk("wr_swdata", s_wdata, 32'h1234_5678);
    chk("wr_rdata", o.d, 32'h0);
    chk("wr_err", o.e, 1'b0);
    // Distractor responses from the other targets while waiting on target 0.
    distract = 1;
    txn(32'h0000_0100, 32'h0, 0, 0, 3, 32'h0000_00AA); wait_idle();
    distract = 0;
    pop_obs(o);
    chk("distract_data", o.d, 32'h0000_00AA);
    // Target 3 never responds; then a request to target 0 must still work.
    txn(32'h3000_0000, 32'h0, 0, 0, 1000, 32'h1); n0 = t_n; wait_idle();
    pop_obs(o);
    chk("to_latency", o.c - n0, TO + 1);
    chk("to_err", o.e, 1'b1);
    chk("to_rdata", o.d, 32'h0);
    txn(32'h3000_0000, 32'h0, 0, 1000, 0, 32'h1); n0 = t_n; wait_idle();
    pop_obs(o);
    chk("to_issue_latency", o.c - n0, TO + 1);
    chk("to_issue_err", o.e, 1'b1);
    txn(32'h0000_0000, 32'h0, 0, 0, 0, 32'h0000_0055); wait_idle();
    pop_obs(o);
    chk("after_to_data", o.d, 32'h0000_0055);
    chk("after_to_err", o.e, 1'b0);
    // Async reset during ISSUE, then during WAIT.
    txn(32'h1000_0020, 32'h0, 0, 5, 0, 32'h77);
    chk("issue_sreq", s_req_valid, 4'b0010);
    #1 rst_n = 0; model_reset();
    #1 chk("arst_issue_sreq", s_req_valid, 4'b0000);
    chk("arst_issue_ready", m_req_ready, 1'b1);
    end_cycle();
    #1 rst_n = 1;
    end_cycle();
    txn(32'h2000_0020, 32'h0, 0, 0, 5, 32'h88);
    end_cycle();
    obs_q.delete();
    #1 rst_n = 0; model_reset();
    #1 chk("arst_wait_ready", m_req_ready, 1'b1);
    chk("arst_wait_sreq", s_req_valid, 4'b0000);
    chk("arst_wait_resp", m_resp_valid, 1'b0);
    repeat (2) end_cycle();
    #1 rst_n = 1;
    repeat (8) end_cycle();
    chk("arst_no_resp", obs_q.size(), 0);
    txn(32'h2000_0000, 32'h0, 0, 0, 0, 32'h0BAD_F00D); wait_idle();
    pop_obs(o);
    chk("arst_fresh_data", o.d, 32'h0BAD_F00D);
    // Back-to-back reads with valid held high.
    txn(32'h0000_0000, 32'h0, 0, 0, 0, 32'hA0);
    txn(32'h3000_0000, 32'h0, 0, 0, 0, 32'hA3); wait_idle();
    pop_obs(o); pop_obs(o2);
    chk("b2b_first", o.d, 32'hA0);
    chk("b2b_second", o2.d, 32'hA3);
    chk("b2b_spacing", o2.c - o.c, 4);
    // Randomized traffic with noisy non-selected targets.
    noise = 1;
    repeat (250) begin
      distract = ($urandom_range(0, 3) == 0);
      txn($urandom, $urandom, 1'($urandom), $urandom_range(0, 9),
          ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 8), $urandom);
      if ($urandom_range(0, 2) != 0) wait_idle();
      repeat ($urandom_range(0, 2)) end_cycle();
    end
    wait_idle();
    repeat (2) end_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
